// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared types for the LC-3b split-cache memory arbiter.
package lc3b_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } lc3b_arb_state;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } lc3b_requester;

endpackage

// File: rtl/lc3b_mem_arbiter_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module lc3b_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Round-robin arbiter putting the I-cache and D-cache line ports onto one
// physical memory port, one line transaction outstanding at a time.
//
// state  | meaning
// IDLE   | sample requests, grant one, latch address/op/wdata
// I_BUSY | memory command issued on behalf of the I-cache
// D_BUSY | memory command issued on behalf of the D-cache
// DONE   | one quiet cycle so the served requester can drop its request
module lc3b_mem_arbiter
    import lc3b_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int OFFS_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    input  logic              perf_clear,
    output logic [CNT_W-1:0]  perf_i_grants,
    output logic [CNT_W-1:0]  perf_d_grants,
    output logic [CNT_W-1:0]  perf_conflicts
);

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFS_W){1'b1}}, {OFFS_W{1'b0}}};

    lc3b_arb_state state_q, state_d;
    lc3b_requester last_grant_q, last_grant_d;

    logic              op_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic i_req, d_req;
    logic grant_i, grant_d, conflict;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_i      = 1'b0;
        grant_d      = 1'b0;
        conflict     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    conflict = 1'b1;
                    // Tie goes to whoever was not served last.
                    if (last_grant_q == REQ_D) grant_i = 1'b1;
                    else                       grant_d = 1'b1;
                end else if (i_req) begin
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end
                if (grant_i) state_d = I_BUSY;
                if (grant_d) state_d = D_BUSY;
            end
            I_BUSY: begin
                pmem_read  = ~op_write_q;
                pmem_write = op_write_q;
                if (pmem_resp) begin
                    i_resp       = 1'b1;
                    last_grant_d = REQ_I;
                    state_d      = DONE;
                end
            end
            D_BUSY: begin
                pmem_read  = ~op_write_q;
                pmem_write = op_write_q;
                if (pmem_resp) begin
                    d_resp       = 1'b1;
                    last_grant_d = REQ_D;
                    state_d      = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_D;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            if (grant_i) begin
                addr_q     <= i_addr & LINE_MASK;
                op_write_q <= 1'b0;
            end
            // A simultaneous read+write from the D-cache is a writeback.
            if (grant_d) begin
                addr_q     <= d_addr & LINE_MASK;
                op_write_q <= d_write;
                wdata_q    <= d_wdata;
            end
        end
    end

    assign pmem_addr  = addr_q;
    assign pmem_wdata = wdata_q;
    assign i_rdata    = pmem_rdata;
    assign d_rdata    = pmem_rdata;

    lc3b_sat_counter #(.CNT_W(CNT_W)) u_cnt_i_grants (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (i_resp),
        .clr   (perf_clear),
        .count (perf_i_grants)
    );

    lc3b_sat_counter #(.CNT_W(CNT_W)) u_cnt_d_grants (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (d_resp),
        .clr   (perf_clear),
        .count (perf_d_grants)
    );

    lc3b_sat_counter #(.CNT_W(CNT_W)) u_cnt_conflicts (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (conflict),
        .clr   (perf_clear),
        .count (perf_conflicts)
    );

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Self-checking bench for lc3b_mem_arbiter; small counters make saturation reachable.
module tb_lc3b_mem_arbiter;

    localparam int ADDR_W  = 16;
    localparam int LINE_W  = 128;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              perf_clear;
    logic [CNT_W-1:0]  perf_i_grants;
    logic [CNT_W-1:0]  perf_d_grants;
    logic [CNT_W-1:0]  perf_conflicts;

    int n_vec;
    int n_err;

    // Reference model: who was served last (0 = I, 1 = D) and the three counts.
    int m_last;
    int m_ig;
    int m_dg;
    int m_cf;

    lc3b_mem_arbiter #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .OFFS_W (4),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_read         (i_read),
        .i_addr         (i_addr),
        .i_rdata        (i_rdata),
        .i_resp         (i_resp),
        .d_read         (d_read),
        .d_write        (d_write),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_rdata        (d_rdata),
        .d_resp         (d_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_addr      (pmem_addr),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp),
        .perf_clear     (perf_clear),
        .perf_i_grants  (perf_i_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_conflicts (perf_conflicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last = 1;
        m_ig   = 0;
        m_dg   = 0;
        m_cf   = 0;
    endtask

    // Runs one complete arbitration from IDLE; requests must already be driven.
    task automatic do_txn(input int lat, input bit clr_at_resp, input bit stray,
                          input bit drop_mid, output int served);
        int                g;
        logic [ADDR_W-1:0] exp_addr;
        logic [LINE_W-1:0] exp_wdata;
        bit                exp_wr;
        logic [LINE_W-1:0] rd;
        logic [LINE_W-1:0] got_rd;
        if (i_read && (d_read || d_write)) begin
            g    = (m_last == 1) ? 0 : 1;
            m_cf = sat_inc(m_cf);
        end else if (i_read) begin
            g = 0;
        end else begin
            g = 1;
        end
        exp_addr  = ((g == 0) ? i_addr : d_addr) & 16'hFFF0;
        exp_wr    = (g == 1) && d_write;
        exp_wdata = d_wdata;

        pmem_resp = stray;
        @(negedge clk);
        n_vec++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000)
            $display("FAIL idle_quiet: got %b want 0000", {pmem_read, pmem_write, i_resp, d_resp});
        tick();
        pmem_resp = 1'b0;

        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            n_vec++;
            if ({pmem_read, pmem_write} !== {~exp_wr, exp_wr}) begin
                n_err++;
                $display("FAIL busy_cmd: got rd=%b wr=%b want rd=%b wr=%b", pmem_read, pmem_write, ~exp_wr, exp_wr);
            end
            n_vec++;
            if (pmem_addr !== exp_addr) begin
                n_err++;
                $display("FAIL busy_addr: got %h want %h", pmem_addr, exp_addr);
            end
            if (exp_wr) begin
                n_vec++;
                if (pmem_wdata !== exp_wdata) begin
                    n_err++;
                    $display("FAIL busy_wdata: got %h want %h", pmem_wdata, exp_wdata);
                end
            end
            n_vec++;
            if ({i_resp, d_resp} !== 2'b00) begin
                n_err++;
                $display("FAIL early_resp: got %b want 00", {i_resp, d_resp});
            end
            tick();
            if (g == 0) begin
                i_addr = 16'($urandom);
                if (drop_mid) i_read = 1'b0;
            end else begin
                d_addr  = 16'($urandom);
                d_wdata = {$urandom, $urandom, $urandom, $urandom};
                if (drop_mid) begin
                    d_read  = 1'b0;
                    d_write = 1'b0;
                end
            end
        end

        rd         = {$urandom, $urandom, $urandom, $urandom};
        pmem_rdata = rd;
        pmem_resp  = 1'b1;
        perf_clear = clr_at_resp;
        @(negedge clk);
        n_vec++;
        if ({i_resp, d_resp} !== ((g == 0) ? 2'b10 : 2'b01)) begin
            n_err++;
            $display("FAIL resp: got i=%b d=%b want served=%0d", i_resp, d_resp, g);
        end
        got_rd = (g == 0) ? i_rdata : d_rdata;
        n_vec++;
        if (got_rd !== rd) begin
            n_err++;
            $display("FAIL rdata: got %h want %h", got_rd, rd);
        end
        n_vec++;
        if ({pmem_read, pmem_write} !== {~exp_wr, exp_wr}) begin
            n_err++;
            $display("FAIL resp_cmd: got rd=%b wr=%b want wr=%b", pmem_read, pmem_write, exp_wr);
        end
        tick();
        pmem_resp  = stray;
        perf_clear = 1'b0;
        if (g == 0) i_read = 1'b0;
        else begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        if (clr_at_resp) begin
            m_ig = 0;
            m_dg = 0;
            m_cf = 0;
        end else if (g == 0) m_ig = sat_inc(m_ig);
        else                 m_dg = sat_inc(m_dg);
        m_last = g;

        @(negedge clk);
        n_vec++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
            n_err++;
            $display("FAIL done_quiet: got %b want 0000", {pmem_read, pmem_write, i_resp, d_resp});
        end
        n_vec++;
        if (perf_i_grants !== CNT_W'(m_ig)) begin
            n_err++;
            $display("FAIL cnt_i: got %0d want %0d", perf_i_grants, m_ig);
        end
        n_vec++;
        if (perf_d_grants !== CNT_W'(m_dg)) begin
            n_err++;
            $display("FAIL cnt_d: got %0d want %0d", perf_d_grants, m_dg);
        end
        n_vec++;
        if (perf_conflicts !== CNT_W'(m_cf)) begin
            n_err++;
            $display("FAIL cnt_conf: got %0d want %0d", perf_conflicts, m_cf);
        end
        tick();
        pmem_resp = 1'b0;
        served    = g;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        i_read     = 1'b0;
        i_addr     = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        perf_clear = 1'b0;
        model_reset();
        @(negedge clk);
        n_vec++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want 0000", {pmem_read, pmem_write, i_resp, d_resp});
        end
        n_vec++;
        if ({pmem_addr, pmem_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_regs: got addr=%h wdata=%h want 0", pmem_addr, pmem_wdata);
        end
        n_vec++;
        if ({perf_i_grants, perf_d_grants, perf_conflicts} !== '0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d %0d %0d want 0", perf_i_grants, perf_d_grants, perf_conflicts);
        end
        tick();
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_tie();
        int s;
        i_read  = 1'b1;
        i_addr  = 16'h2222;
        d_read  = 1'b1;
        d_addr  = 16'h3333;
        do_txn(2, 1'b0, 1'b0, 1'b0, s);
        n_vec++;
        if (s != 0) begin
            n_err++;
            $display("FAIL tie_first: served %0d want 0 (I)", s);
        end
        do_txn(2, 1'b0, 1'b0, 1'b0, s);
        n_vec++;
        if (s != 1) begin
            n_err++;
            $display("FAIL tie_second: served %0d want 1 (D)", s);
        end
        n_vec++;
        if (perf_conflicts !== CNT_W'(1)) begin
            n_err++;
            $display("FAIL tie_conf: got %0d want 1", perf_conflicts);
        end
    endtask

    task automatic test_i_read();
        int s;
        i_read = 1'b1;
        i_addr = 16'h1234;
        do_txn(3, 1'b0, 1'b1, 1'b0, s);
        n_vec++;
        if (perf_i_grants !== CNT_W'(2)) begin
            n_err++;
            $display("FAIL i_read_cnt: got %0d want 2", perf_i_grants);
        end
    endtask

    task automatic test_d_write();
        int s;
        d_write = 1'b1;
        d_read  = 1'b1;
        d_addr  = 16'h40F7;
        d_wdata = {16{8'hA5}};
        do_txn(4, 1'b0, 1'b1, 1'b1, s);
    endtask

    task automatic test_contention();
        int s;
        int cf0;
        int order[4];
        cf0    = m_cf;
        i_read = 1'b1;
        i_addr = 16'($urandom);
        d_read = 1'b1;
        d_addr = 16'($urandom);
        for (int t = 0; t < 4; t++) begin
            do_txn($urandom_range(1, 3), 1'b0, 1'b0, 1'b0, s);
            order[t] = s;
            if (s == 0) begin
                i_read = 1'b1;
                i_addr = 16'($urandom);
            end else begin
                d_read = 1'b1;
                d_addr = 16'($urandom);
            end
        end
        n_vec++;
        if (order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
            n_err++;
            $display("FAIL contention_order: got %0d%0d%0d%0d want 0101", order[0], order[1], order[2], order[3]);
        end
        n_vec++;
        if (int'(perf_conflicts) != cf0 + 4) begin
            n_err++;
            $display("FAIL contention_conf: got %0d want %0d", perf_conflicts, cf0 + 4);
        end
        // Leave with no requests pending.
        do_txn(1, 1'b0, 1'b0, 1'b0, s);
        do_txn(1, 1'b0, 1'b0, 1'b0, s);
    endtask

    task automatic test_reset_mid();
        int s;
        d_write = 1'b1;
        d_addr  = 16'hBEEF;
        d_wdata = {4{$urandom}};
        @(negedge clk);
        tick();
        @(negedge clk);
        n_vec++;
        if (pmem_write !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre: got pmem_write=%b want 1", pmem_write);
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            n_err++;
            $display("FAIL rstmid_cmd: got %b want 00", {pmem_read, pmem_write});
        end
        pmem_resp = 1'b1;
        #1;
        n_vec++;
        if ({i_resp, d_resp} !== 2'b00) begin
            n_err++;
            $display("FAIL rstmid_resp: got %b want 00", {i_resp, d_resp});
        end
        n_vec++;
        if ({perf_i_grants, perf_d_grants, perf_conflicts} !== '0) begin
            n_err++;
            $display("FAIL rstmid_cnt: got %0d %0d %0d want 0", perf_i_grants, perf_d_grants, perf_conflicts);
        end
        tick();
        pmem_resp = 1'b0;
        d_write   = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        tick();
        i_read = 1'b1;
        i_addr = 16'h5A5A;
        do_txn(2, 1'b0, 1'b0, 1'b0, s);
        n_vec++;
        if (s != 0 || perf_i_grants !== CNT_W'(1)) begin
            n_err++;
            $display("FAIL rstmid_after: served %0d cnt %0d want 0 and 1", s, perf_i_grants);
        end
    endtask

    task automatic test_saturation();
        int s;
        for (int t = 0; t < CNT_MAX + 3; t++) begin
            i_read = 1'b1;
            i_addr = 16'($urandom);
            do_txn(1, 1'b0, 1'b0, 1'b0, s);
        end
        n_vec++;
        if (perf_i_grants !== CNT_W'(CNT_MAX)) begin
            n_err++;
            $display("FAIL sat_hold: got %0d want %0d", perf_i_grants, CNT_MAX);
        end
        i_read = 1'b1;
        i_addr = 16'($urandom);
        do_txn(1, 1'b1, 1'b0, 1'b0, s);
        n_vec++;
        if (perf_i_grants !== '0) begin
            n_err++;
            $display("FAIL sat_clear: got %0d want 0", perf_i_grants);
        end
    endtask

    task automatic test_random();
        int s;
        int mode;
        for (int t = 0; t < 60; t++) begin
            if (!i_read && ($urandom_range(0, 1) == 1)) begin
                i_read = 1'b1;
                i_addr = 16'($urandom);
            end
            if (!(d_read || d_write) && (($urandom_range(0, 1) == 1) || !i_read)) begin
                mode    = $urandom_range(0, 2);
                d_read  = (mode != 1);
                d_write = (mode != 0);
                d_addr  = 16'($urandom);
                d_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            do_txn($urandom_range(1, 4), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0), s);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_tie();
        test_i_read();
        test_d_write();
        test_contention();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
